instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Byte-stream program loader: the write side of the 256x8 instruction memory.
//  Takes framed bytes (typically from the UART receiver) over valid/ready.
//  Writes the payload into instruction memory from address 0 upward.
//  Holds the CPU in reset until a frame loads with a good checksum.
//  Frame format: SYNC, LEN (0 means 256), LEN data bytes, CSUM.
//  CSUM is the 8-bit sum of the data bytes.
// PARAMETERS
//  SYNC_BYTE  8'hA5  frame start marker
//  TIMEOUT    16'd50000  max idle cycles between bytes inside a frame
// PORTS
//  clock        in   1  system clock
//  reset_n      in   1  asynchronous reset, active-low
//  in_data      in   8  received byte
//  in_valid     in   1  in_data valid this cycle
//  in_ready     out  1  loader accepts byte (handshake = in_valid & in_ready)
//  mem_addr     out  8  instruction memory write address
//  mem_w_data   out  8  instruction memory write data
//  mem_w_en     out  1  instruction memory write strobe, one cycle per byte
//  cpu_reset    out  1  active-high reset to CPU core and instruction fetch
//  load_done    out  1  last frame loaded and verified
//  load_err     out  1  last frame failed (checksum or timeout)
// BEHAVIOUR
//  Reset (async, reset_n=0) sets every output as follows:
//   - state IDLE; cpu_reset=1; load_done=0; load_err=0
//   - mem_w_en=0; mem_addr=0; mem_w_data=0; in_ready=0
//   - internal count=0; sum=0; timer=0
//  in_ready=1 in every state except during reset. The loader never stalls.
//  FSM; transitions occur only on an accepted byte unless noted:
//   IDLE: byte==SYNC_BYTE -> LEN. Any other byte is discarded.
//   LEN: latch len (0 => 256); count=0; sum=0 -> DATA.
//   DATA: each byte is registered, then written on the next cycle:
//    - mem_w_en=1, mem_addr=count, mem_w_data=byte (one-cycle latency)
//    - sum+=byte (mod 256); count+=1
//    - after the len-th byte -> CSUM
//   CSUM: byte==sum -> DONE (load_done=1, cpu_reset=0).
//         byte!=sum -> ERROR (load_err=1).
//   DONE: byte==SYNC_BYTE -> LEN, and on the same edge:
//    - cpu_reset=1, load_done=0, load_err=0
//    - other bytes are ignored
//   ERROR: cpu_reset stays 1. byte==SYNC_BYTE -> LEN and clears load_err.
//  A SYNC_BYTE value inside LEN, DATA or CSUM is ordinary data, not a restart.
//  Back-to-back bytes (in_valid held high) are accepted every cycle, giving
//   one write strobe per cycle.
//  Timeout (LEN/DATA/CSUM only):
//   - timer clears on every accepted byte and increments otherwise
//   - timer==TIMEOUT-1 with no byte -> ERROR
//   - a byte arriving in that same cycle wins and the timer clears
//  Counter width is 9 bits, so len=256 terminates correctly.
//  mem_addr wraps naturally and never exceeds 255.
//  cpu_reset is registered and glitch-free:
//   - it rises on the SYNC edge
//   - it falls only on the edge entering DONE
//  The CPU must not drive instruction memory while cpu_reset=1. The top-level
//   address mux selects mem_addr when cpu_reset=1.
//  Reset mid-frame aborts immediately; the memory contents are left partial.
// STRUCTURE
//  Shared header (loader_defs.vh): state encodings, SYNC_BYTE and TIMEOUT defaults.
//  Single module with no sub-modules. One FSM, a 9-bit count, an 8-bit sum
//   and a 16-bit timer.
// TESTING
//  1. Release reset -> cpu_reset=1, load_done=0, in_ready=1, mem_w_en=0.
//  2. Send A5 03 11 22 33 66:
//     - writes (0,11), (1,22), (2,33), each one cycle after its byte
//     - then load_done=1, cpu_reset=0
//  3. Send A5 02 01 02 04 -> no further effect after the writes:
//     - load_err=1, cpu_reset=1, load_done=0
//     - a following A5 01 7F 7F -> load_done=1
//  4. Send A5 00, 256 bytes of value i, then CSUM 80:
//     - 256 writes, addr 0..255 with data=addr
//     - load_done=1
//  5. Send A5 04 01, then idle TIMEOUT cycles -> load_err=1, cpu_reset=1.
//  6. After DONE, send A5 01 A5 A5:
//     - cpu_reset rises on the first A5
//     - mem[0]=A5, then load_done=1
//     - reset_n pulsed mid-DATA -> all outputs return to reset values

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, framing defaults
// and the LEN-byte decode helper.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam logic [15:0] TIMEOUT_DEF   = 16'd50000;

    // A LEN byte of zero stands for a full 256-byte image.
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input handshake plus the instruction-memory write port of the loader.
interface instr_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_w_data;
    logic       mem_w_en;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_addr,
        input  mem_w_data,
        input  mem_w_en
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_addr,
        output mem_w_data,
        output mem_w_en
    );

endinterface

// File: rtl/instr_loader.sv
// Framed byte-stream loader for the 256x8 instruction memory; keeps the CPU in
// reset until a frame with a matching checksum has been written.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | hunting for SYNC, all other bytes dropped
//  ST_LEN   | next byte is the payload length (0 = 256)
//  ST_DATA  | payload bytes, each written to mem one cycle after arrival
//  ST_CSUM  | next byte is compared against the running 8-bit sum
//  ST_DONE  | image verified, CPU released; SYNC starts a reload
//  ST_ERROR | checksum or timeout failure, CPU held; SYNC retries
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [15:0] TIMEOUT   = TIMEOUT_DEF
) (
    input  logic           clock,
    input  logic           reset_n,
    instr_loader_if.slave  lif,
    output logic           cpu_reset,
    output logic           load_done,
    output logic           load_err
);

    state_t      state;
    logic [8:0]  len;
    logic [8:0]  count;
    logic [7:0]  sum;
    logic [15:0] timer;

    logic accept;
    logic is_sync;
    logic in_frame;
    logic timed_out;

    assign accept    = lif.in_valid & lif.in_ready;
    assign is_sync   = (lif.in_data == SYNC_BYTE);
    assign in_frame  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
    // An arriving byte always beats the timeout in the same cycle.
    assign timed_out = in_frame && !accept && (timer == TIMEOUT - 16'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            cpu_reset      <= 1'b1;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            lif.in_ready   <= 1'b0;
            lif.mem_w_en   <= 1'b0;
            lif.mem_addr   <= 8'd0;
            lif.mem_w_data <= 8'd0;
            len            <= 9'd0;
            count          <= 9'd0;
            sum            <= 8'd0;
            timer          <= 16'd0;
        end else begin
            lif.in_ready <= 1'b1;
            lif.mem_w_en <= 1'b0;

            if (in_frame && !accept)
                timer <= timer + 16'd1;
            else
                timer <= 16'd0;

            if (timed_out) begin
                state    <= ST_ERROR;
                load_err <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept && is_sync)
                            state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (accept) begin
                            len   <= frame_len(lif.in_data);
                            count <= 9'd0;
                            sum   <= 8'd0;
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (accept) begin
                            lif.mem_w_en   <= 1'b1;
                            lif.mem_addr   <= count[7:0];
                            lif.mem_w_data <= lif.in_data;
                            sum            <= sum + lif.in_data;
                            count          <= count + 9'd1;
                            if (count + 9'd1 == len)
                                state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (accept) begin
                            if (lif.in_data == sum) begin
                                state     <= ST_DONE;
                                load_done <= 1'b1;
                                cpu_reset <= 1'b0;
                            end else begin
                                state    <= ST_ERROR;
                                load_err <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (accept && is_sync) begin
                            state     <= ST_LEN;
                            cpu_reset <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                        end
                    end
                    ST_ERROR: begin
                        if (accept && is_sync) begin
                            state    <= ST_LEN;
                            load_err <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed frames plus randomized frames checked against
// a frame-level model (payload -> expected writes, checksum -> expected outcome).
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam logic [15:0] TO   = 16'd64;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic cpu_reset;
    logic load_done;
    logic load_err;

    instr_loader_if lif ();

    instr_loader #(.SYNC_BYTE(SYNC), .TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .lif       (lif),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;
    int n_wr  = 0;
    logic [7:0] pay[$];

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(negedge clock)
        if (reset_n && lif.mem_w_en === 1'b1)
            n_wr++;

    task automatic idle(input int n);
        lif.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        lif.in_data  = b;
        lif.in_valid = 1'b1;
        @(posedge clock);
        #1;
        lif.in_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int max_gap);
        if (max_gap == 0) return 0;
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, max_gap));
        return int'($urandom_range(0, 2));
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk_val({tag, "_ready"}, lif.in_ready, 0);
        chk_val({tag, "_cpurst"}, cpu_reset, 1);
        chk_val({tag, "_done"}, load_done, 0);
        chk_val({tag, "_err"}, load_err, 0);
        chk_val({tag, "_wen"}, lif.mem_w_en, 0);
        chk_val({tag, "_addr"}, lif.mem_addr, 0);
        chk_val({tag, "_wdata"}, lif.mem_w_data, 0);
    endtask

    // Sends SYNC, LEN, pay[], CSUM (correct sum + csum_delta) and checks every
    // write plus the final outcome implied by the frame contents.
    task automatic send_frame(input logic [7:0] csum_delta, input int max_gap);
        logic [7:0] lb;
        logic [7:0] s;
        int wr0;
        bit good;
        lb   = (pay.size() == 256) ? 8'd0 : 8'(pay.size());
        s    = 8'd0;
        foreach (pay[i]) s = s + pay[i];
        good = (csum_delta == 8'd0);
        wr0  = n_wr;

        idle(pick_gap(max_gap));
        send_byte(SYNC);
        chk_val("sync_cpurst", cpu_reset, 1);
        chk_val("sync_done", load_done, 0);
        idle(pick_gap(max_gap));
        send_byte(lb);
        foreach (pay[i]) begin
            idle(pick_gap(max_gap));
            send_byte(pay[i]);
            chk_val("wr_en", lif.mem_w_en, 1);
            chk_val("wr_addr", lif.mem_addr, i & 255);
            chk_val("wr_data", lif.mem_w_data, pay[i]);
        end
        idle(pick_gap(max_gap));
        send_byte(s + csum_delta);
        chk_val("end_done", load_done, good);
        chk_val("end_err", load_err, !good);
        chk_val("end_cpurst", cpu_reset, !good);
        chk_val("end_ready", lif.in_ready, 1);
        idle(1);
        chk_val("wr_count", n_wr - wr0, pay.size());
    endtask

    initial begin
        int wr0;
        lif.in_valid = 1'b0;
        lif.in_data  = 8'h00;

        // Reset values, then release
        repeat (3) @(posedge clock);
        #1;
        chk_reset_vals("rst");
        reset_n = 1'b1;
        idle(1);
        chk_val("post_ready", lif.in_ready, 1);
        chk_val("post_cpurst", cpu_reset, 1);
        chk_val("post_done", load_done, 0);
        chk_val("post_wen", lif.mem_w_en, 0);

        pay = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h00, 0);

        pay = '{8'h01, 8'h02};
        send_frame(8'h01, 0);
        pay = '{8'h7F};
        send_frame(8'h00, 0);

        pay.delete();
        for (int i = 0; i < 256; i++) pay.push_back(8'(i));
        send_frame(8'h00, 0);

        // Non-SYNC bytes in DONE are ignored
        wr0 = n_wr;
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(8'hFF);
        idle(1);
        chk_val("done_hold", load_done, 1);
        chk_val("done_cpurst", cpu_reset, 0);
        chk_val("done_nowr", n_wr - wr0, 0);

        pay = '{8'hA5};
        send_frame(8'h00, 0);

        // Idle timeout inside DATA: still alive one cycle before the limit
        send_byte(SYNC);
        send_byte(8'h04);
        send_byte(8'h01);
        idle(int'(TO) - 1);
        chk_val("pre_to_err", load_err, 0);
        idle(1);
        chk_val("to_err", load_err, 1);
        chk_val("to_cpurst", cpu_reset, 1);
        chk_val("to_done", load_done, 0);

        // A byte on the very cycle the timer would expire wins
        send_byte(SYNC);
        chk_val("retry_err_clr", load_err, 0);
        send_byte(8'h04);
        send_byte(8'h01);
        idle(int'(TO) - 1);
        send_byte(8'h02);
        chk_val("race_wen", lif.mem_w_en, 1);
        chk_val("race_addr", lif.mem_addr, 1);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h0A);
        chk_val("race_done", load_done, 1);
        chk_val("race_err", load_err, 0);

        for (int f = 0; f < 40; f++) begin
            int n_junk;
            int len;
            logic [7:0] b;
            n_junk = int'($urandom_range(0, 3));
            for (int j = 0; j < n_junk; j++) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                send_byte(b);
            end
            len = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(1, 40));
            pay.delete();
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0)
                send_frame(8'($urandom_range(1, 255)), int'(TO) - 1);
            else
                send_frame(8'h00, int'(TO) - 1);
        end

        // Reset pulse in the middle of DATA aborts the frame
        send_byte(SYNC);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h02);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        idle(2);
        reset_n = 1'b1;
        idle(1);
        chk_val("mid_ready", lif.in_ready, 1);
        pay = '{8'hC3, 8'h3C};
        send_frame(8'h00, 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
